// File: rtl/program_loader_pkg.sv
// Shared encodings and helpers for the serial program loader.
// Imported by uart_rx and program_loader.
package program_loader_pkg;

   typedef enum logic [1:0] {
      LOADER_STATE_RECV_LEN  = 2'd0,
      LOADER_STATE_RECV_DATA = 2'd1,
      LOADER_STATE_DONE      = 2'd2,
      LOADER_STATE_ERROR     = 2'd3
   } loader_state_t;

   typedef enum logic [1:0] {
      UART_IDLE  = 2'd0,
      UART_START = 2'd1,
      UART_DATA  = 2'd2,
      UART_STOP  = 2'd3
   } uart_state_t;

   localparam int UART_DATA_BITS        = 8;
   localparam int LOADER_BYTES_PER_WORD = 4;

   // Little-endian byte insert: lane 0 is bits [7:0].
   function automatic logic [31:0] set_lane(
      input logic [31:0] w,
      input logic [1:0]  lane,
      input logic [7:0]  b
   );
      logic [31:0] r;
      r = w;
      r[{lane, 3'b000} +: 8] = b;
      return r;
   endfunction

endpackage

// File: rtl/program_loader_uart_rx.sv
// 8N1 UART receiver, LSB first, with 2-flop input synchroniser.
// Emits one-cycle byte_valid or frame_error pulses per frame.
module uart_rx
   import program_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rxd,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       frame_error
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(UART_DATA_BITS);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(UART_DATA_BITS - 1);

   uart_state_t r_state;
   uart_state_t w_state_n;
   logic [1:0]    r_sync;
   logic          r_prev;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_n;
   logic [BW-1:0] r_bit;
   logic [BW-1:0] w_bit_n;
   logic [7:0]    r_shift;
   logic [7:0]    w_shift_n;
   logic          r_valid;
   logic          w_valid_n;
   logic          r_ferr;
   logic          w_ferr_n;
   logic          w_rx;

   assign w_rx        = r_sync[1];
   assign byte_valid  = r_valid;
   assign byte_data   = r_shift;
   assign frame_error = r_ferr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync  <= 2'b11;
         r_prev  <= 1'b1;
         r_state <= UART_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], rxd};
         r_prev  <= w_rx;
         r_state <= w_state_n;
         r_cnt   <= w_cnt_n;
         r_bit   <= w_bit_n;
         r_shift <= w_shift_n;
         r_valid <= w_valid_n;
         r_ferr  <= w_ferr_n;
      end
   end

   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt + 1'b1;
      w_bit_n   = r_bit;
      w_shift_n = r_shift;
      w_valid_n = 1'b0;
      w_ferr_n  = 1'b0;
      unique case (r_state)
         UART_IDLE: begin
            w_cnt_n = '0;
            if (r_prev && !w_rx) w_state_n = UART_START;
         end
         UART_START: begin
            // A start bit that has gone high again by mid-bit is a glitch.
            if (r_cnt == HALF_M1) begin
               w_cnt_n   = '0;
               w_bit_n   = '0;
               w_state_n = w_rx ? UART_IDLE : UART_DATA;
            end
         end
         UART_DATA: begin
            if (r_cnt == FULL_M1) begin
               w_cnt_n   = '0;
               w_shift_n = {w_rx, r_shift[7:1]};
               if (r_bit == LAST_BIT) w_state_n = UART_STOP;
               else                   w_bit_n   = r_bit + 1'b1;
            end
         end
         UART_STOP: begin
            if (r_cnt == FULL_M1) begin
               w_cnt_n   = '0;
               w_state_n = UART_IDLE;
               w_valid_n = w_rx;
               w_ferr_n  = !w_rx;
            end
         end
         default: w_state_n = UART_IDLE;
      endcase
   end

endmodule

// File: rtl/program_loader.sv
// Boot loader: length-prefixed UART image written word by word to ROM.
// Holds the core in reset until the whole image is stored.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int ADDR_WIDTH   = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  rxd,
   output logic                  rom_wren,
   output logic [ADDR_WIDTH-1:0] rom_address,
   output logic [31:0]           rom_write_data,
   output logic                  cpu_reset_n,
   output logic                  load_done,
   output logic                  load_error
);

   localparam int IW = ADDR_WIDTH - 1;
   localparam logic [31:0] CAPACITY = 32'd1 << (ADDR_WIDTH - 2);
   localparam logic [1:0]  LAST_LANE = 2'(LOADER_BYTES_PER_WORD - 1);

   logic       w_byte_valid;
   logic [7:0] w_byte_data;
   logic       w_frame_error;

   uart_rx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_uart_rx (
      .clk        (clk),
      .reset_n    (reset_n),
      .rxd        (rxd),
      .byte_valid (w_byte_valid),
      .byte_data  (w_byte_data),
      .frame_error(w_frame_error)
   );

   loader_state_t r_state, w_state_n;
   logic [31:0]           r_len,   w_len_n;
   logic [1:0]            r_cnt,   w_cnt_n;
   logic [31:0]           r_word,  w_word_n;
   logic [IW-1:0]         r_idx,   w_idx_n;
   logic                  r_last,  w_last_n;
   logic                  r_wren,  w_wren_n;
   logic [ADDR_WIDTH-1:0] r_addr,  w_addr_n;
   logic [31:0]           r_wdata, w_wdata_n;
   logic                  r_cpu,   w_cpu_n;
   logic                  r_done,  w_done_n;
   logic                  r_err,   w_err_n;
   logic [31:0]           w_len_asm;
   logic [31:0]           w_word_asm;
   logic                  w_is_last;

   assign rom_wren       = r_wren;
   assign rom_address    = r_addr;
   assign rom_write_data = r_wdata;
   assign cpu_reset_n    = r_cpu;
   assign load_done      = r_done;
   assign load_error     = r_err;

   assign w_len_asm  = set_lane(r_len,  r_cnt, w_byte_data);
   assign w_word_asm = set_lane(r_word, r_cnt, w_byte_data);
   assign w_is_last  = (32'(r_idx) == r_len - 32'd1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= LOADER_STATE_RECV_LEN;
         r_len   <= '0;
         r_cnt   <= '0;
         r_word  <= '0;
         r_idx   <= '0;
         r_last  <= 1'b0;
         r_wren  <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_cpu   <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_len   <= w_len_n;
         r_cnt   <= w_cnt_n;
         r_word  <= w_word_n;
         r_idx   <= w_idx_n;
         r_last  <= w_last_n;
         r_wren  <= w_wren_n;
         r_addr  <= w_addr_n;
         r_wdata <= w_wdata_n;
         r_cpu   <= w_cpu_n;
         r_done  <= w_done_n;
         r_err   <= w_err_n;
      end
   end

   always_comb begin
      w_state_n = r_state;
      w_len_n   = r_len;
      w_cnt_n   = r_cnt;
      w_word_n  = r_word;
      w_idx_n   = r_idx;
      w_last_n  = 1'b0;
      w_wren_n  = 1'b0;
      w_addr_n  = r_addr;
      w_wdata_n = r_wdata;
      w_cpu_n   = r_cpu;
      w_done_n  = r_done;
      w_err_n   = r_err;
      unique case (r_state)
         LOADER_STATE_RECV_LEN: begin
            if (w_frame_error) begin
               w_state_n = LOADER_STATE_ERROR;
               w_err_n   = 1'b1;
            end else if (w_byte_valid) begin
               w_len_n = w_len_asm;
               w_cnt_n = r_cnt + 1'b1;
               if (r_cnt == LAST_LANE) begin
                  if (w_len_asm == 32'd0) begin
                     w_state_n = LOADER_STATE_DONE;
                     w_done_n  = 1'b1;
                     w_cpu_n   = 1'b1;
                  end else if (w_len_asm > CAPACITY) begin
                     w_state_n = LOADER_STATE_ERROR;
                     w_err_n   = 1'b1;
                  end else begin
                     w_state_n = LOADER_STATE_RECV_DATA;
                  end
               end
            end
         end
         LOADER_STATE_RECV_DATA: begin
            // r_last marks the cycle the final word is on the ROM port.
            if (r_last) begin
               w_state_n = LOADER_STATE_DONE;
               w_done_n  = 1'b1;
               w_cpu_n   = 1'b1;
            end else if (w_frame_error) begin
               w_state_n = LOADER_STATE_ERROR;
               w_err_n   = 1'b1;
            end else if (w_byte_valid) begin
               w_word_n = w_word_asm;
               w_cnt_n  = r_cnt + 1'b1;
               if (r_cnt == LAST_LANE) begin
                  w_wren_n  = 1'b1;
                  w_wdata_n = w_word_asm;
                  w_addr_n  = {r_idx[IW-2:0], 2'b00};
                  w_idx_n   = r_idx + 1'b1;
                  w_last_n  = w_is_last;
               end
            end
         end
         LOADER_STATE_DONE:  ;
         LOADER_STATE_ERROR: ;
         default: w_state_n = LOADER_STATE_ERROR;
      endcase
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: UART frames in, ROM writes checked.
// Small CLKS_PER_BIT and ADDR_WIDTH keep frames short and capacity 64 words.
module tb_program_loader;

   localparam int CPB = 4;
   localparam int AW  = 8;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          rxd = 1'b1;
   logic          rom_wren;
   logic [AW-1:0] rom_address;
   logic [31:0]   rom_write_data;
   logic          cpu_reset_n;
   logic          load_done;
   logic          load_error;

   program_loader #(
      .CLKS_PER_BIT(CPB),
      .ADDR_WIDTH  (AW)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .rxd           (rxd),
      .rom_wren      (rom_wren),
      .rom_address   (rom_address),
      .rom_write_data(rom_write_data),
      .cpu_reset_n   (cpu_reset_n),
      .load_done     (load_done),
      .load_error    (load_error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   logic [AW-1:0] wr_addr[$];
   logic [31:0]   wr_data[$];
   int            wr_cyc[$];
   int            dbl = 0;
   logic          prev_wren = 1'b0;
   int            done_cyc = -1;

   always @(negedge clk) begin
      if (rom_wren === 1'b1) begin
         wr_addr.push_back(rom_address);
         wr_data.push_back(rom_write_data);
         wr_cyc.push_back(cyc);
         if (prev_wren) dbl++;
      end
      prev_wren = (rom_wren === 1'b1);
      if (load_done !== 1'b1) done_cyc = -1;
      else if (done_cyc < 0) done_cyc = cyc;
   end

   int n_vec = 0;
   int n_bad = 0;
   int t_last = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
      @(negedge clk);
      rxd = 1'b0;
      t_last = cyc;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (CPB) @(negedge clk);
      end
      rxd = stop;
      repeat (CPB) @(negedge clk);
      rxd = 1'b1;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_wren"}, 32'(rom_wren), 32'd0);
      chk({tag, "_addr"}, 32'(rom_address), 32'd0);
      chk({tag, "_data"}, rom_write_data, 32'd0);
      chk({tag, "_cpu"},  32'(cpu_reset_n), 32'd0);
      chk({tag, "_done"}, 32'(load_done), 32'd0);
      chk({tag, "_err"},  32'(load_error), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   int b;
   int d;

   initial begin
      repeat (3) @(negedge clk);
      check_reset("rst");
      reset_n = 1'b1;
      repeat (3) @(negedge clk);

      // Two-word image.
      b = wr_addr.size();
      d = dbl;
      send_word(32'd2);
      chk("t1_pre_done", 32'(load_done), 32'd0);
      send_word(32'h0000_0013);
      send_word(32'h0000_10B7);
      repeat (5) @(negedge clk);
      chk("t1_nwr",   32'(wr_addr.size() - b), 32'd2);
      chk("t1_addr0", 32'(wr_addr[b]), 32'h00);
      chk("t1_data0", wr_data[b], 32'h0000_0013);
      chk("t1_addr1", 32'(wr_addr[b+1]), 32'h04);
      chk("t1_data1", wr_data[b+1], 32'h0000_10B7);
      chk("t1_pulse", 32'(dbl - d), 32'd0);
      chk("t1_done_t", 32'(done_cyc), 32'(wr_cyc[b+1] + 1));
      chk("t1_done",  32'(load_done), 32'd1);
      chk("t1_cpu",   32'(cpu_reset_n), 32'd1);
      chk("t1_err",   32'(load_error), 32'd0);
      chk("t1_hold_a", 32'(rom_address), 32'h04);
      chk("t1_hold_d", rom_write_data, 32'h0000_10B7);

      // Empty image: done the cycle after the 4th length byte.
      do_reset();
      b = wr_addr.size();
      send_word(32'd0);
      chk("t2_done_t", 32'(done_cyc), 32'(t_last + 42));
      chk("t2_done", 32'(load_done), 32'd1);
      chk("t2_cpu",  32'(cpu_reset_n), 32'd1);
      send_byte(8'hAA);
      repeat (5) @(negedge clk);
      chk("t2_nwr",  32'(wr_addr.size() - b), 32'd0);
      chk("t2_done2", 32'(load_done), 32'd1);

      // Oversize image.
      do_reset();
      b = wr_addr.size();
      send_word(32'd65);
      send_word(32'h4433_2211);
      repeat (5) @(negedge clk);
      chk("t3_err",  32'(load_error), 32'd1);
      chk("t3_cpu",  32'(cpu_reset_n), 32'd0);
      chk("t3_done", 32'(load_done), 32'd0);
      chk("t3_nwr",  32'(wr_addr.size() - b), 32'd0);

      // Framing error, then recovery via reset.
      do_reset();
      b = wr_addr.size();
      send_word(32'd1);
      send_byte(8'h55, 1'b0);
      send_byte(8'h66);
      send_byte(8'h77);
      send_byte(8'h88);
      repeat (5) @(negedge clk);
      chk("t4_err", 32'(load_error), 32'd1);
      chk("t4_cpu", 32'(cpu_reset_n), 32'd0);
      chk("t4_nwr", 32'(wr_addr.size() - b), 32'd0);
      do_reset();
      chk("t4_err_clr", 32'(load_error), 32'd0);
      b = wr_addr.size();
      send_word(32'd1);
      send_word(32'hDEAD_BEEF);
      repeat (5) @(negedge clk);
      chk("t4_nwr2", 32'(wr_addr.size() - b), 32'd1);
      chk("t4_addr", 32'(wr_addr[b]), 32'h00);
      chk("t4_data", wr_data[b], 32'hDEAD_BEEF);
      chk("t4_done", 32'(load_done), 32'd1);

      // One-cycle glitch while idle is not a start bit.
      do_reset();
      b = wr_addr.size();
      @(negedge clk);
      rxd = 1'b0;
      @(negedge clk);
      rxd = 1'b1;
      repeat (60) @(negedge clk);
      chk("t5_nwr0", 32'(wr_addr.size() - b), 32'd0);
      chk("t5_err0", 32'(load_error), 32'd0);
      chk("t5_done0", 32'(load_done), 32'd0);
      send_word(32'd1);
      send_word(32'h0000_0013);
      repeat (5) @(negedge clk);
      chk("t5_nwr", 32'(wr_addr.size() - b), 32'd1);
      chk("t5_addr", 32'(wr_addr[b]), 32'h00);
      chk("t5_data", wr_data[b], 32'h0000_0013);
      chk("t5_done", 32'(load_done), 32'd1);

      // Reset in the middle of the second word of a 3-word load.
      do_reset();
      b = wr_addr.size();
      send_word(32'd3);
      send_word(32'h1234_5678);
      send_byte(8'h9A);
      send_byte(8'hBC);
      chk("t6_mid_data", rom_write_data, 32'h1234_5678);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check_reset("t6_rst");
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      b = wr_addr.size();
      send_word(32'd1);
      send_word(32'hCAFE_F00D);
      repeat (5) @(negedge clk);
      chk("t6_nwr",  32'(wr_addr.size() - b), 32'd1);
      chk("t6_addr", 32'(wr_addr[b]), 32'h00);
      chk("t6_data", wr_data[b], 32'hCAFE_F00D);
      chk("t6_done", 32'(load_done), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Serial boot loader that writes the instruction memory the core fetches from.
- Receives a program over a UART line (8N1, LSB first) and assembles little-endian bytes into 32-bit words.
- Writes each word through the ROM write port at consecutive byte addresses 0, 4, 8, ...
- Holds the core in reset until the whole image is stored, then releases it.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); minimum 4
ADDR_WIDTH, 16, ROM byte-address width; capacity = 2^(ADDR_WIDTH-2) words

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
rxd  input  1  UART receive line, idle high, asynchronous to clk
rom_wren  output  1  one-cycle write strobe to instruction memory
rom_address  output  ADDR_WIDTH  byte address of the word being written (bits [1:0] always 0)
rom_write_data  output  32  word being written
cpu_reset_n  output  1  reset to the core's pipeline; low while loading
load_done  output  1  image fully written (sticky)
load_error  output  1  framing error or oversize image (sticky)

Behaviour:
- Interface: one clock (clk); reset_n is asynchronous and active-low.
- Reset values: rom_wren=0, rom_address=0, rom_write_data=0, cpu_reset_n=0, load_done=0, load_error=0, FSM=RECV_LEN, all counters 0.
- reset_n asserted mid-load aborts immediately. The partial image is not cleared; the next load restarts at address 0.
- UART receive, in sub-module uart_rx:
  - rxd passes through a 2-flop synchroniser.
  - A start bit is a high-to-low transition seen while idle.
  - Sample the start bit at CLKS_PER_BIT/2 (integer division); if it reads high, return to idle (glitch, no byte).
  - Sample data bits every CLKS_PER_BIT thereafter, LSB first.
  - Stop bit sampled high: byte_valid pulses for 1 cycle with the byte.
  - Stop bit sampled low: frame_error pulses for 1 cycle and no byte is produced.
  - After the stop-bit sample the receiver returns to idle and is ready for the next start edge.
- Load protocol: 4-byte little-endian word count N, then N words of 4 bytes each, little-endian.
- FSM states:
  - RECV_LEN: collect 4 bytes into N.
    - After the 4th byte: N==0 -> DONE; N > 2^(ADDR_WIDTH-2) -> ERROR; otherwise -> RECV_DATA.
  - RECV_DATA: shift each byte into a word register at lane byte_count[1:0].
    - On the 4th byte of a word: the cycle after that byte_valid, drive rom_wren=1 for exactly one cycle, with rom_write_data = the assembled word and rom_address = word_index<<2.
    - Then increment word_index. rom_address and rom_write_data hold their values until the next write.
    - After the write of word N-1: -> DONE.
  - DONE:
    - load_done=1 and cpu_reset_n=1, both registered and asserted the cycle after the last rom_wren (or the cycle after the 4th length byte when N==0).
    - Further bytes are ignored. Exit only via reset_n.
  - ERROR: load_error=1, cpu_reset_n stays 0, all bytes ignored. Exit only via reset_n.
- frame_error in RECV_LEN or RECV_DATA -> ERROR on the next cycle. A frame_error in DONE is ignored.
- Byte spacing is at least 10*CLKS_PER_BIT cycles, so a write never collides with the next byte_valid. No backpressure from memory: the ROM accepts a write every cycle.
- word_index width is ADDR_WIDTH-1 bits so that a full-capacity count fits; N is compared as 32 bits.

Decomposition:
- Shared definitions header:
  - state encodings LOADER_STATE_RECV_LEN/RECV_DATA/DONE/ERROR (2 bits)
  - UART_DATA_BITS=8
  - LOADER_BYTES_PER_WORD=4
- Sub-module uart_rx:
  - parameter CLKS_PER_BIT
  - ports clk, reset_n, rxd, byte_valid, byte_data[7:0], frame_error
  - internal states IDLE/START/DATA/STOP
- program_loader instantiates one uart_rx plus the load FSM.

Test Plan (bench uses CLKS_PER_BIT=4, ADDR_WIDTH=8):
- Send N=2 (bytes 02 00 00 00), then 13 00 00 00 and B7 10 00 00 -> writes (0x00, 0x00000013) and (0x04, 0x000010B7), each rom_wren exactly 1 cycle; load_done and cpu_reset_n rise the cycle after the 2nd write.
- Send N=0 -> no rom_wren; load_done=1 and cpu_reset_n=1 the cycle after the 4th length byte; subsequent byte AA produces no write.
- Send N=65 (capacity 64) -> ERROR: load_error=1, cpu_reset_n stays 0, no rom_wren even when data bytes follow.
- Send N=1, then a byte with stop bit driven low -> load_error=1, no write; assert reset_n low, then reload N=1 with word DEADBEEF -> write (0x00, 0xDEADBEEF) and load_done=1.
- Drive a 1-cycle low glitch on rxd while idle -> no byte_valid, no state change; then a valid load of N=1 with word 00000013 succeeds.
- Assert reset_n low in the middle of the 2nd word of an N=3 load -> all outputs return to reset values immediately; a fresh N=1 load writes to address 0x00.
